// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t  : fetch FSM states (IDLE, REQ, WAIT)
//   fetch_entry_t  : {instr, pc} pair held by the IF/ID register and skid buffer
//   FETCH_WIDTH    : default address/instruction width
//   FETCH_RESET_PC : default PC after reset
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned FETCH_WIDTH = 32;

  localparam logic [FETCH_WIDTH-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] instr;
    logic [FETCH_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding buffer for fetched instructions that arrive while the
// IF/ID register is occupied and not being consumed.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : load data_i (entry becomes valid)
//   pop_i     : entry consumed (entry becomes empty)
//   flush_i   : discard the entry; wins over push and pop
//   data_i    : entry to store
//   valid_o   : buffer holds an entry
//   data_o    : stored entry
// The entry type is a parameter so the buffer follows the fetch width.
// -----------------------------------------------------------------------------
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter type T = fetch_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  T     data_i,
  output logic valid_o,
  output T     data_o
);

  logic valid_q, valid_d;
  T     data_q,  data_d;

  // A simultaneous push and pop leaves the buffer full with the new entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : fetch_skid_buf

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the architectural PC, issues single-outstanding
// fetches to instruction memory and presents results to decode through an
// IF/ID register backed by a one-entry skid buffer. Redirects kill any
// in-flight fetch and flush IF/ID and the skid buffer.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   PC_Next_i      : next PC from next-PC logic
//   Redirect_i     : non-sequential PC this cycle (flush)
//   Stall_i        : decode cannot accept this cycle
//   PC_o           : PC of the instruction being fetched
//   Imem_Req_o     : fetch request valid
//   Imem_Addr_o    : fetch address (same as PC_o)
//   Imem_Ready_i   : memory accepts the request
//   Imem_Rvalid_i  : response valid (always accepted)
//   Imem_Rdata_i   : response instruction
//   Instr_Valid_o  : IF/ID holds an instruction
//   Instr_o        : IF/ID instruction
//   Instr_PC_o     : PC of Instr_o
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = FETCH_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC_Next_i,
  input  logic             Redirect_i,
  input  logic             Stall_i,
  output logic [WIDTH-1:0] PC_o,
  output logic             Imem_Req_o,
  output logic [WIDTH-1:0] Imem_Addr_o,
  input  logic             Imem_Ready_i,
  input  logic             Imem_Rvalid_i,
  input  logic [WIDTH-1:0] Imem_Rdata_i,
  output logic             Instr_Valid_o,
  output logic [WIDTH-1:0] Instr_o,
  output logic [WIDTH-1:0] Instr_PC_o
);

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             kill_q, kill_d;
  logic             ifid_valid_q, ifid_valid_d;
  entry_t           ifid_q, ifid_d;

  logic   skid_push, skid_pop, skid_flush, skid_valid;
  entry_t skid_data, resp_entry;

  logic consume;
  logic resp_ok;
  logic skid_empty_next;

  // Decode takes the IF/ID entry this cycle.
  assign consume    = ifid_valid_q && !Stall_i;
  // A response is delivered only in WAIT, when not killed and not overridden
  // by a redirect in the same cycle.
  assign resp_ok    = (state_q == WAIT) && Imem_Rvalid_i && !kill_q && !Redirect_i;
  assign resp_entry = '{instr: Imem_Rdata_i, pc: pc_q};

  // ---------------------------------------------------------------------------
  // IF/ID register and skid buffer control
  // ---------------------------------------------------------------------------
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_d       = ifid_q;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
    skid_flush   = 1'b0;

    if (Redirect_i) begin
      ifid_valid_d = 1'b0;
      skid_flush   = 1'b1;
    end else begin
      if (consume) begin
        if (skid_valid) begin
          ifid_d   = skid_data;
          skid_pop = 1'b1;
        end else begin
          ifid_valid_d = 1'b0;
        end
      end
      if (resp_ok) begin
        // IF/ID is free if empty, or drained this cycle with nothing
        // queued behind it; otherwise the response waits in the skid.
        if (!ifid_valid_q || (consume && !skid_valid)) begin
          ifid_d       = resp_entry;
          ifid_valid_d = 1'b1;
        end else begin
          skid_push = 1'b1;
        end
      end
    end
  end

  assign skid_empty_next = skid_flush || (!skid_push && (!skid_valid || skid_pop));

  // ---------------------------------------------------------------------------
  // Fetch FSM and PC next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;

    // PC moves only on redirect or on a delivered response, so the request
    // address stays stable while a request waits for ready.
    if (Redirect_i || resp_ok) begin
      pc_d = PC_Next_i;
    end

    case (state_q)
      IDLE: begin
        if (!skid_valid || Redirect_i) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (Imem_Ready_i) begin
          state_d = WAIT;
          // Accepted with the old address while redirecting: drop its reply.
          kill_d  = Redirect_i;
        end
      end
      WAIT: begin
        if (Imem_Rvalid_i) begin
          state_d = skid_empty_next ? REQ : IDLE;
          kill_d  = 1'b0;
        end else if (Redirect_i) begin
          kill_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_q       <= ifid_d;
    end
  end

  fetch_skid_buf #(
    .T (entry_t)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .flush_i (skid_flush),
    .data_i  (resp_entry),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  assign PC_o          = pc_q;
  assign Imem_Addr_o   = pc_q;
  assign Imem_Req_o    = (state_q == REQ);
  assign Instr_Valid_o = ifid_valid_q;
  assign Instr_o       = ifid_q.instr;
  assign Instr_PC_o    = ifid_q.pc;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Bench for fetch_stage: a memory model with configurable ready and response
// latency, a next-PC model (PC+4 or redirect target), and a scoreboard of
// expected {instr, pc} entries pushed when a live response is returned and
// popped when decode consumes an instruction.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC_Next_i = '0;
  logic        Redirect_i = 1'b0;
  logic        Stall_i = 1'b0;
  logic [31:0] PC_o;
  logic        Imem_Req_o;
  logic [31:0] Imem_Addr_o;
  logic        Imem_Ready_i = 1'b0;
  logic        Imem_Rvalid_i = 1'b0;
  logic [31:0] Imem_Rdata_i = '0;
  logic        Instr_Valid_o;
  logic [31:0] Instr_o;
  logic [31:0] Instr_PC_o;

  fetch_stage #(
    .WIDTH    (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_Next_i     (PC_Next_i),
    .Redirect_i    (Redirect_i),
    .Stall_i       (Stall_i),
    .PC_o          (PC_o),
    .Imem_Req_o    (Imem_Req_o),
    .Imem_Addr_o   (Imem_Addr_o),
    .Imem_Ready_i  (Imem_Ready_i),
    .Imem_Rvalid_i (Imem_Rvalid_i),
    .Imem_Rdata_i  (Imem_Rdata_i),
    .Instr_Valid_o (Instr_Valid_o),
    .Instr_o       (Instr_o),
    .Instr_PC_o    (Instr_PC_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  ent_t        sb[$];
  logic        pend = 1'b0;
  logic        killed = 1'b0;
  int          cnt = 0;
  int          lat = 1;
  logic        ready_en = 1'b1;
  logic [31:0] acc_addr = '0;
  logic [31:0] acc_exp = '0;
  logic [31:0] exp_pc = '0;
  logic        armed = 1'b0;
  vec_t        tbl[14];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[23:0] ^ 24'h5A5A5A, 8'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: at the falling edge sample outputs, then drive the inputs
  // seen by the next rising edge and update the models.
  task automatic cyc(input logic r, input logic stall, input logic redir, input logic [31:0] tgt);
    ent_t e;
    @(negedge clk);
    if (armed) check("pc", PC_o, exp_pc);
    rst        = r;
    Stall_i    = stall;
    Redirect_i = redir;
    PC_Next_i  = redir ? tgt : PC_o + 32'd4;

    if (armed && !r && Instr_Valid_o && !stall && !redir) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL consume: got instr at pc %h expected none", Instr_PC_o);
      end else begin
        e = sb.pop_front();
        check("instr", Instr_o, e.instr);
        check("instr_pc", Instr_PC_o, e.pc);
      end
    end

    Imem_Rvalid_i = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        Imem_Rvalid_i = 1'b1;
        Imem_Rdata_i  = instr_of(acc_addr);
        pend          = 1'b0;
        if (!killed && !redir && !r) begin
          sb.push_back('{instr: instr_of(acc_exp), pc: acc_exp});
          exp_pc = exp_pc + 32'd4;
        end
        killed = 1'b0;
      end else begin
        cnt--;
      end
    end

    Imem_Ready_i = 1'b0;
    if (!r && armed && Imem_Req_o && !pend && ready_en) begin
      Imem_Ready_i = 1'b1;
      check("req_addr", Imem_Addr_o, exp_pc);
      pend     = 1'b1;
      cnt      = lat - 1;
      acc_addr = Imem_Addr_o;
      acc_exp  = exp_pc;
      killed   = redir;
    end else if (pend && (redir || r)) begin
      killed = 1'b1;
    end

    if (r) begin
      sb.delete();
      exp_pc = RST_PC;
      armed  = 1'b1;
    end else if (redir) begin
      sb.delete();
      exp_pc = tgt;
    end
  endtask

  task automatic wait_accept(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      if (Imem_Ready_i) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_accept: got no acceptance expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_req(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      if (Imem_Req_o) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_req: got no request expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_valid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      if (Instr_Valid_o) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_valid: got no instr expected one within %0d cycles", budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    // Zero-wait memory from reset, then a 4-cycle stall that sends 0x104 to
    // the skid buffer. Rows are sampled at the falling edge.
    //            stall  req   addr          valid  ipc
    tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0100};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0104};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_0108, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0108};
    tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 32'h0000_0110, 1'b1, 32'h0000_010C};

    lat      = 1;
    ready_en = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 14; i++) begin
      cyc(1'b0, tbl[i].stall, 1'b0, 32'h0);
      check1($sformatf("row%0d_req", i), Imem_Req_o, tbl[i].req);
      if (tbl[i].req) check($sformatf("row%0d_addr", i), Imem_Addr_o, tbl[i].addr);
      check1($sformatf("row%0d_valid", i), Instr_Valid_o, tbl[i].valid);
      if (tbl[i].valid) check($sformatf("row%0d_ipc", i), Instr_PC_o, tbl[i].ipc);
    end

    // Redirect to 0x200 in WAIT; the stale response lands 3 cycles later.
    lat = 4;
    wait_accept(20);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check1("A_valid_flushed", Instr_Valid_o, 1'b0);
    check1("A_no_req_killed", Imem_Req_o, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check1("A_no_req_killed2", Imem_Req_o, 1'b0);
    lat = 1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check1("A_no_req_at_rvalid", Imem_Req_o, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check1("A_req_tgt", Imem_Req_o, 1'b1);
    check("A_addr_tgt", Imem_Addr_o, 32'h0000_0200);
    wait_valid(10);
    check("A_ipc", Instr_PC_o, 32'h0000_0200);

    // Redirect to 0x300 in the same cycle as rvalid.
    wait_accept(20);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0300);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check1("B_valid", Instr_Valid_o, 1'b0);
    check1("B_req", Imem_Req_o, 1'b1);
    check("B_addr", Imem_Addr_o, 32'h0000_0300);
    wait_valid(10);
    check("B_ipc", Instr_PC_o, 32'h0000_0300);

    // Ready held low in REQ: address stable, then a redirect to 0x400.
    ready_en = 1'b0;
    wait_req(10);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      check1($sformatf("C_req%0d", i), Imem_Req_o, 1'b1);
      check($sformatf("C_addr%0d", i), Imem_Addr_o, exp_pc);
    end
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0400);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check1("C_req_after_redir", Imem_Req_o, 1'b1);
    check("C_addr_after_redir", Imem_Addr_o, 32'h0000_0400);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("C_addr_hold", Imem_Addr_o, 32'h0000_0400);
    ready_en = 1'b1;
    wait_valid(10);
    check("C_ipc", Instr_PC_o, 32'h0000_0400);

    // Reset while in WAIT; the late response must be ignored.
    lat = 3;
    wait_accept(20);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    lat = 1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check1("D_valid", Instr_Valid_o, 1'b0);
    check1("D_idle", Imem_Req_o, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check1("D_req", Imem_Req_o, 1'b1);
    check("D_addr", Imem_Addr_o, RST_PC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check1("D_late_ignored", Instr_Valid_o, 1'b0);
    wait_valid(10);
    check("D_ipc", Instr_PC_o, RST_PC);

    // Mixed traffic: random stalls, ready, latency and occasional redirects.
    for (int i = 0; i < 400; i++) begin
      logic        st;
      logic        rd;
      logic [31:0] tg;
      ready_en = ($urandom_range(0, 3) != 0);
      lat      = $urandom_range(1, 3);
      st       = ($urandom_range(0, 2) == 0);
      rd       = ($urandom_range(0, 19) == 0);
      tg       = 32'h0000_1000 + {20'h0, 8'($urandom_range(0, 255)), 4'h0};
      cyc(1'b0, st, rd, tg);
    end
    ready_en = 1'b1;
    lat      = 1;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_stage
